// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: FSM state
// encoding, completion status codes and header field layout.
package router_pkg;

    // Header layout: {len, dest}
    localparam int HDR_DEST_W   = 2;
    localparam int HDR_LEN_W    = 6;
    localparam int HDR_W        = HDR_DEST_W + HDR_LEN_W;

    // Destination code the router has no output port for
    localparam int DEST_INVALID = 3;

    // Transmitter FSM states
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_HEADER   = 3'd2;
    localparam logic [2:0] S_PAYLOAD  = 3'd3;
    localparam logic [2:0] S_PARITY   = 3'd4;
    localparam logic [2:0] S_WAIT_ERR = 3'd5;

    // Completion status reported alongside done
    typedef enum logic [1:0] {
        ST_OK   = 2'b00,
        ST_PERR = 2'b01,
        ST_REJ  = 2'b10,
        ST_TMO  = 2'b11
    } status_e;

endpackage

// File: rtl/pkt_tx_buffer.sv
// Payload store for one packet: register array with a synchronous write
// port, a combinational read port at the read pointer plus a look-ahead
// read at rd_ptr+1 so the registered data_out can be loaded one byte early.
module pkt_tx_buffer
    import router_pkg::*;
#(
    parameter int LEN_W = HDR_LEN_W,
    parameter int DW    = HDR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [DW-1:0]    wr_data_i,
    input  logic             rd_adv_i,
    output logic [LEN_W-1:0] wr_ptr_o,
    output logic [LEN_W-1:0] rd_ptr_o,
    output logic [DW-1:0]    rd_data_o,
    output logic [DW-1:0]    rd_next_o
);

    localparam int DEPTH = 2 ** LEN_W;

    logic [DW-1:0]    mem_q [DEPTH];
    logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;

    // Byte storage write port
    // NOTE: the array has no reset; every entry read is written first in
    // the same packet, and a resettable array would become flops with a
    // reset tree instead of plain storage.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointer next-state: clear wins over advance
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en_i)  wr_ptr_d = wr_ptr_q + LEN_W'(1);
            if (rd_adv_i) rd_ptr_d = rd_ptr_q + LEN_W'(1);
        end
    end

    // Pointer registers
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign wr_ptr_o  = wr_ptr_q;
    assign rd_ptr_o  = rd_ptr_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign rd_next_o = mem_q[rd_ptr_q + LEN_W'(1)];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter feeding the 1x3 router input. Buffers a whole payload,
// then emits header, payload and parity as a gap-free burst under busy
// back-pressure, and reports completion with the router's parity verdict.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int DEST_W  = HDR_DEST_W,
    parameter int LEN_W   = HDR_LEN_W,
    parameter int DW      = HDR_W,
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DEST_W-1:0] cmd_dest,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DW-1:0]     s_data,
    output logic              pkt_valid,
    output logic [DW-1:0]     data_out,
    input  logic              busy,
    input  logic              err,
    output logic              done,
    output logic [1:0]        status
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [2:0]        state_q, state_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DW-1:0]     par_q, par_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_q, err_d;
    logic              pkt_valid_q, pkt_valid_d;
    logic [DW-1:0]     data_q, data_d;
    logic              done_q, done_d;
    logic [1:0]        status_q, status_d;

    logic              buf_clr, buf_wr, buf_rd_adv;
    logic [LEN_W-1:0]  wr_ptr, rd_ptr, last_idx;
    logic [DW-1:0]     rd_data, rd_next;
    logic              in_flight;
    logic              rejected;

    pkt_tx_buffer #(
        .LEN_W (LEN_W),
        .DW    (DW)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (buf_clr),
        .wr_en_i   (buf_wr),
        .wr_data_i (s_data),
        .rd_adv_i  (buf_rd_adv),
        .wr_ptr_o  (wr_ptr),
        .rd_ptr_o  (rd_ptr),
        .rd_data_o (rd_data),
        .rd_next_o (rd_next)
    );

    assign last_idx  = len_q - LEN_W'(1);
    assign in_flight = (state_q == S_HEADER) || (state_q == S_PAYLOAD) ||
                       (state_q == S_PARITY) || (state_q == S_WAIT_ERR);
    assign rejected  = (cmd_dest == DEST_W'(DEST_INVALID)) || (cmd_len == '0);

    // Handshake readies decode straight from state
    assign cmd_ready = (state_q == S_IDLE);
    assign s_ready   = (state_q == S_LOAD);

    // FSM next-state and registered-output next values
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        len_d       = len_q;
        par_d       = par_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        pkt_valid_d = pkt_valid_q;
        data_d      = data_q;
        done_d      = 1'b0;
        status_d    = status_q;
        buf_clr     = 1'b0;
        buf_wr      = 1'b0;
        buf_rd_adv  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (rejected) begin
                        done_d   = 1'b1;
                        status_d = ST_REJ;
                    end else begin
                        dest_d  = cmd_dest;
                        len_d   = cmd_len;
                        par_d   = {cmd_len, cmd_dest};
                        err_d   = 1'b0;
                        tmo_d   = '0;
                        buf_clr = 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (s_valid) begin
                    buf_wr = 1'b1;
                    par_d  = par_q ^ s_data;
                    if (wr_ptr == last_idx) begin
                        state_d     = S_HEADER;
                        pkt_valid_d = 1'b1;
                        data_d      = {len_q, dest_q};
                    end
                end
            end
            S_HEADER: begin
                if (!busy) begin
                    state_d = S_PAYLOAD;
                    data_d  = rd_data;
                end
            end
            S_PAYLOAD: begin
                if (!busy) begin
                    if (rd_ptr == last_idx) begin
                        state_d     = S_PARITY;
                        pkt_valid_d = 1'b0;
                        data_d      = par_q;
                    end else begin
                        buf_rd_adv = 1'b1;
                        data_d     = rd_next;
                    end
                end
            end
            S_PARITY: begin
                if (!busy) begin
                    state_d = S_WAIT_ERR;
                    data_d  = '0;
                end
            end
            S_WAIT_ERR: begin
                err_d = err_q | err;
                if (!busy) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    status_d = (err_q | err) ? ST_PERR : ST_OK;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Stalled-router watchdog overrides any in-flight progress
        if (in_flight) begin
            if (busy) begin
                if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d     = S_IDLE;
                    pkt_valid_d = 1'b0;
                    data_d      = '0;
                    done_d      = 1'b1;
                    status_d    = ST_TMO;
                    tmo_d       = '0;
                    buf_clr     = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end else begin
                tmo_d = '0;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            dest_q      <= '0;
            len_q       <= '0;
            par_q       <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            pkt_valid_q <= 1'b0;
            data_q      <= '0;
            done_q      <= 1'b0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            len_q       <= len_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            pkt_valid_q <= pkt_valid_d;
            data_q      <= data_d;
            done_q      <= done_d;
            status_q    <= status_d;
        end
    end

    assign pkt_valid = pkt_valid_q;
    assign data_out  = data_q;
    assign done      = done_q;
    assign status    = status_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: expected router beats are queued as
// stimulus is driven and compared as the transmitter emits them.
module tb_router_pkt_tx;

    localparam int TIMEOUT = 32;

    typedef struct packed {
        logic       pv;
        logic [7:0] data;
    } beat_t;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_dest;
    logic [5:0] cmd_len;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       busy;
    logic       err;
    logic       done;
    logic [1:0] status;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    beat_t      exp_q[$];
    logic [7:0] pay [64];

    router_pkt_tx #(
        .DEST_W  (2),
        .LEN_W   (6),
        .DW      (8),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dest  (cmd_dest),
        .cmd_len   (cmd_len),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .pkt_valid (pkt_valid),
        .data_out  (data_out),
        .busy      (busy),
        .err       (err),
        .done      (done),
        .status    (status)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a command, stream its payload and queue the expected beats
    task automatic load_packet(input logic [1:0] dest, input logic [5:0] len, input bit gaps);
        logic [7:0] hdr;
        logic [7:0] par;
        hdr = {len, dest};
        par = hdr;
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_dest  = dest;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
        exp_q.push_back({1'b1, hdr});
        for (int i = 0; i < int'(len); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    s_valid = 1'b0;
                    tick();
                    check("no_early_valid", pkt_valid, 0);
                end
            end
            s_valid = 1'b1;
            s_data  = pay[i];
            if (i == 0) check("s_ready_load", s_ready, 1);
            tick();
            par = par ^ pay[i];
            exp_q.push_back({1'b1, pay[i]});
        end
        s_valid = 1'b0;
        exp_q.push_back({1'b0, par});
    endtask

    // Drain the scoreboard, optionally stalling one beat with busy high
    task automatic collect(input int stall_idx, input int stall_len);
        beat_t b;
        int    idx;
        idx = 0;
        while (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            check("pkt_valid", pkt_valid, b.pv);
            check("data_out", data_out, b.data);
            check("no_done_in_burst", done, 0);
            if (idx == stall_idx) begin
                repeat (stall_len) begin
                    busy = 1'b1;
                    tick();
                    check("hold_data", data_out, b.data);
                    check("hold_valid", pkt_valid, b.pv);
                end
            end
            busy = 1'b0;
            tick();
            idx++;
        end
    endtask

    // Wait out the error window and check the completion pulse
    task automatic finish_packet(input logic [1:0] exp_status, input bit err_pulse);
        check("done_window", done, 0);
        check("wait_valid_low", pkt_valid, 0);
        if (err_pulse) begin
            busy = 1'b1;
            err  = 1'b1;
            tick();
            err  = 1'b0;
            check("done_while_busy", done, 0);
        end
        busy = 1'b0;
        tick();
        check("done", done, 1);
        check("status", status, exp_status);
        tick();
        check("done_one_cycle", done, 0);
        check("cmd_ready_after", cmd_ready, 1);
    endtask

    task automatic reject(input logic [1:0] dest, input logic [5:0] len);
        cmd_valid = 1'b1;
        cmd_dest  = dest;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
        check("rej_done", done, 1);
        check("rej_status", status, 2);
        check("rej_s_ready", s_ready, 0);
        check("rej_cmd_ready", cmd_ready, 1);
        tick();
        check("rej_done_clear", done, 0);
        check("rej_s_ready_after", s_ready, 0);
    endtask

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_dest  = '0;
        cmd_len   = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        busy      = 1'b0;
        err       = 1'b0;

        // Reset state
        #1;
        check("rst_pkt_valid", pkt_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_done", done, 0);
        check("rst_status", status, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_s_ready", s_ready, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        tick();

        // Basic packet: dest 1, len 3
        pay[0] = 8'h11;
        pay[1] = 8'h22;
        pay[2] = 8'h33;
        load_packet(2'd1, 6'd3, 1'b0);
        collect(-1, 0);
        finish_packet(2'b00, 1'b0);

        // Back-pressure on payload byte 0x22
        load_packet(2'd1, 6'd3, 1'b0);
        collect(2, 4);
        finish_packet(2'b00, 1'b0);

        // Router parity error during the error window
        pay[0] = 8'h5A;
        pay[1] = 8'hC3;
        load_packet(2'd2, 6'd2, 1'b0);
        collect(-1, 0);
        finish_packet(2'b01, 1'b1);

        // Rejected commands
        reject(2'd3, 6'd5);
        reject(2'd0, 6'd0);

        // Timeout while the header is stalled
        pay[0] = 8'hA5;
        load_packet(2'd2, 6'd1, 1'b0);
        check("tmo_header", data_out, {6'd1, 2'd2});
        busy = 1'b1;
        repeat (TIMEOUT - 1) tick();
        check("tmo_valid_before", pkt_valid, 1);
        check("tmo_done_before", done, 0);
        tick();
        check("tmo_valid_drop", pkt_valid, 0);
        check("tmo_done", done, 1);
        check("tmo_status", status, 3);
        busy = 1'b0;
        tick();
        check("tmo_cmd_ready", cmd_ready, 1);
        check("tmo_done_clear", done, 0);
        exp_q.delete();

        // Full-length packet with random source gaps
        for (int i = 0; i < 63; i++) pay[i] = 8'($urandom);
        load_packet(2'd0, 6'd63, 1'b1);
        collect(-1, 0);
        finish_packet(2'b00, 1'b0);

        // Reset asserted mid-payload
        for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
        load_packet(2'd1, 6'd8, 1'b0);
        busy = 1'b0;
        repeat (4) tick();
        check("pre_rst_valid", pkt_valid, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", pkt_valid, 0);
        check("mid_rst_data", data_out, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_status", status, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        #2 rst = 1'b1;
        repeat (6) begin
            tick();
            check("post_rst_no_done", done, 0);
            check("post_rst_valid", pkt_valid, 0);
        end
        exp_q.delete();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
